// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR: state encoding, width helpers
// and the output range reduction (saturating when FIR_MAC_SAT_EN is defined).
package fir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } fir_state_t;

   // Wide enough for any legal DW+CW+clog2(NTAPS) accumulator.
   localparam int MAXW = 128;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int acc_width(input int dw, input int cw, input int ntaps);
      return dw + cw + clog2(ntaps);
   endfunction

   // Brings a shifted accumulator value into ow-bit signed range; the caller keeps the low ow bits.
   function automatic logic signed [MAXW-1:0] reduce_out(input logic signed [MAXW-1:0] v,
                                                        input int ow);
`ifdef FIR_MAC_SAT_EN
      logic signed [MAXW-1:0] one;
      logic signed [MAXW-1:0] hi;
      logic signed [MAXW-1:0] lo;
      one = 1;
      hi  = (one <<< (ow - 1)) - one;
      lo  = -(one <<< (ow - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
`else
      return (v <<< (MAXW - ow)) >>> (MAXW - ow);
`endif
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with a registered accumulator: clr zeroes it,
// en adds the full-width product a*b.
module fir_mac #(
   parameter int DW   = 16,
   parameter int CW   = 16,
   parameter int ACCW = 35
) (
   input  logic                   clk,
   input  logic                   i_rst,
   input  logic                   clr,
   input  logic                   en,
   input  logic signed [DW-1:0]   a,
   input  logic signed [CW-1:0]   b,
   output logic signed [ACCW-1:0] acc
);

   logic signed [DW+CW-1:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + ACCW'(prod);
      end
   end

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed direct-form FIR on one shared MAC, with writable coefficients,
// circular delay line and valid/ready handshakes. Optional macro: FIR_MAC_SAT_EN.
module fir_mac_seq
   import fir_pkg::*;
#(
   parameter int NTAPS = 8,
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int OW    = 18,
   parameter int FRAC  = 15,
   localparam int AW   = clog2(NTAPS),
   localparam int ACCW = acc_width(DW, CW, NTAPS)
) (
   input  logic                 clk,
   input  logic                 i_rst,
   input  logic signed [DW-1:0] i_x,
   input  logic                 i_x_valid,
   output logic                 o_x_ready,
   output logic signed [OW-1:0] o_y,
   output logic                 o_y_valid,
   input  logic                 i_y_ready,
   input  logic                 i_c_we,
   input  logic [AW-1:0]        i_c_addr,
   input  logic signed [CW-1:0] i_c_data,
   output logic                 o_c_err,
   output logic                 o_busy
);

   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
   // o_y/o_y_valid stay frozen while o_y_valid=1 and i_y_ready=0.
   localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

   fir_state_t             state;
   logic [AW-1:0]          wp;
   logic [AW-1:0]          rp;
   logic [AW-1:0]          k;
   logic signed [DW-1:0]   dline [NTAPS];
   logic signed [CW-1:0]   coef  [NTAPS];
   logic signed [ACCW-1:0] acc;
   logic                   xfer;
   logic                   addr_ok;
   logic                   mac_clr;
   logic                   mac_en;
   logic signed [DW-1:0]   mac_a;
   logic signed [CW-1:0]   mac_b;
   logic signed [OW-1:0]   y_next;

   if ((1 << AW) == NTAPS) begin : g_full_addr
      assign addr_ok = 1'b1;
   end else begin : g_part_addr
      assign addr_ok = (i_c_addr <= LAST);
   end

   assign xfer = (state == ST_IDLE) && i_x_valid && o_x_ready;

   always_comb begin
      mac_clr = xfer;
      mac_en  = (state == ST_MAC);
      mac_a   = dline[rp];
      mac_b   = coef[k];
      y_next  = OW'(reduce_out(MAXW'(acc) >>> FRAC, OW));
   end

   fir_mac #(
      .DW   (DW),
      .CW   (CW),
      .ACCW (ACCW)
   ) u_mac (
      .clk   (clk),
      .i_rst (i_rst),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (mac_a),
      .b     (mac_b),
      .acc   (acc)
   );

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         state     <= ST_IDLE;
         wp        <= '0;
         rp        <= '0;
         k         <= '0;
         o_x_ready <= 1'b0;
         o_y       <= '0;
         o_y_valid <= 1'b0;
         o_c_err   <= 1'b0;
         o_busy    <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            dline[i] <= '0;
            coef[i]  <= '0;
         end
      end else begin
         // Writes land only in IDLE, so a same-cycle sample already sees the new tap.
         if (i_c_we) begin
            if ((state == ST_IDLE) && addr_ok) begin
               coef[i_c_addr] <= i_c_data;
               o_c_err        <= 1'b0;
            end else begin
               o_c_err        <= 1'b1;
            end
         end else begin
            o_c_err <= 1'b0;
         end

         unique case (state)
            ST_IDLE: begin
               if (xfer) begin
                  dline[wp] <= i_x;
                  rp        <= wp;
                  wp        <= (wp == LAST) ? '0 : wp + 1'b1;
                  k         <= '0;
                  o_x_ready <= 1'b0;
                  o_busy    <= 1'b1;
                  state     <= ST_MAC;
               end else begin
                  o_x_ready <= 1'b1;
               end
            end
            ST_MAC: begin
               rp <= (rp == '0) ? LAST : rp - 1'b1;
               k  <= k + 1'b1;
               if (k == LAST) state <= ST_OUT;
            end
            ST_OUT: begin
               // First OUT cycle captures the finished accumulator; later cycles wait for the sink.
               if (!o_y_valid) begin
                  o_y       <= y_next;
                  o_y_valid <= 1'b1;
               end else if (i_y_ready) begin
                  o_y_valid <= 1'b0;
                  o_x_ready <= 1'b1;
                  o_busy    <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed plus random bench for fir_mac_seq with a reference FIR model feeding an
// expected-output queue.
module tb_fir_mac_seq;

   localparam int NTAPS = 8;
   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int OW    = 18;
   localparam int FRAC  = 15;
   localparam int AW    = $clog2(NTAPS);

   logic          clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [DW-1:0] i_x = '0;
   logic          i_x_valid = 1'b0;
   logic          o_x_ready;
   logic [OW-1:0] o_y;
   logic          o_y_valid;
   logic          i_y_ready = 1'b1;
   logic          i_c_we = 1'b0;
   logic [AW-1:0] i_c_addr = '0;
   logic [CW-1:0] i_c_data = '0;
   logic          o_c_err;
   logic          o_busy;

   int checks   = 0;
   int failures = 0;

   logic [OW-1:0]        exp_q[$];
   logic signed [DW-1:0] hist [NTAPS];
   logic signed [CW-1:0] mh   [NTAPS];

   logic [OW-1:0] y_obs;
   logic [OW-1:0] y_hold;
   int            lat;
   int            stale;

   int            imp_c [NTAPS] = '{29, 18101, 18101, 29, 0, 0, 0, 0};
   logic [CW-1:0] imp_h [NTAPS] = '{16'h001E, 16'h46B6, 16'h46B6, 16'h001E, 16'h0, 16'h0, 16'h0, 16'h0};

   always #5 clk = ~clk;

   fir_mac_seq #(
      .NTAPS (NTAPS),
      .DW    (DW),
      .CW    (CW),
      .OW    (OW),
      .FRAC  (FRAC)
   ) dut (
      .clk       (clk),
      .i_rst     (i_rst),
      .i_x       (i_x),
      .i_x_valid (i_x_valid),
      .o_x_ready (o_x_ready),
      .o_y       (o_y),
      .o_y_valid (o_y_valid),
      .i_y_ready (i_y_ready),
      .i_c_we    (i_c_we),
      .i_c_addr  (i_c_addr),
      .i_c_data  (i_c_data),
      .o_c_err   (o_c_err),
      .o_busy    (o_busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "simulation timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   function automatic logic [OW-1:0] model_y();
      longint acc;
      longint y;
`ifdef FIR_MAC_SAT_EN
      longint hi;
      longint lo;
`endif
      acc = 0;
      for (int t = 0; t < NTAPS; t++) acc += longint'(mh[t]) * longint'(hist[t]);
      y = acc >>> FRAC;
`ifdef FIR_MAC_SAT_EN
      hi = (longint'(1) <<< (OW - 1)) - 1;
      lo = -(longint'(1) <<< (OW - 1));
      if (y > hi) y = hi;
      if (y < lo) y = lo;
`endif
      return OW'(y);
   endfunction

   task automatic reset_model();
      for (int t = 0; t < NTAPS; t++) begin
         hist[t] = '0;
         mh[t]   = '0;
      end
      exp_q.delete();
   endtask

   task automatic write_coef(input logic [AW-1:0] a, input logic [CW-1:0] d);
      i_c_we   = 1'b1;
      i_c_addr = a;
      i_c_data = d;
      mh[a]    = d;
      @(posedge clk);
      @(negedge clk);
      i_c_we = 1'b0;
      chk("idle_wr_err", 64'(o_c_err), 64'(0));
   endtask

   task automatic send_sample(input logic [DW-1:0] x, input logic we,
                              input logic [AW-1:0] a, input logic [CW-1:0] d);
      int n;
      n = 0;
      while (o_x_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("x_ready_wait", 64'(o_x_ready), 64'(1));
      i_x       = x;
      i_x_valid = 1'b1;
      i_c_we    = we;
      i_c_addr  = a;
      i_c_data  = d;
      if (we) mh[a] = d;
      for (int t = NTAPS - 1; t > 0; t--) hist[t] = hist[t-1];
      hist[0] = x;
      exp_q.push_back(model_y());
      @(posedge clk);
      @(negedge clk);
      i_x_valid = 1'b0;
      i_c_we    = 1'b0;
   endtask

   task automatic recv(output logic [OW-1:0] y, output int l);
      logic [OW-1:0] e;
      int n;
      n = 0;
      while (o_y_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      l = n;
      chk("y_valid_wait", 64'(o_y_valid), 64'(1));
      y = o_y;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_y", 64'($signed(o_y)), 64'($signed(e)));
      end else begin
         chk("sb_unexpected", 64'(exp_q.size()), 64'(1));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset_model();

      // Reset state
      #2 i_rst = 1'b0;
      #1;
      chk("rst_y", 64'(o_y), 64'(0));
      chk("rst_y_valid", 64'(o_y_valid), 64'(0));
      chk("rst_x_ready", 64'(o_x_ready), 64'(0));
      chk("rst_c_err", 64'(o_c_err), 64'(0));
      chk("rst_busy", 64'(o_busy), 64'(0));
      repeat (3) @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      chk("rel_x_ready", 64'(o_x_ready), 64'(1));

      // Impulse response
      for (int t = 0; t < NTAPS; t++) write_coef(AW'(t), imp_h[t]);
      for (int s = 0; s < NTAPS; s++) begin
         send_sample((s == 0) ? 16'h7FFF : 16'h0000, 1'b0, '0, '0);
         if (s == 0) begin
            chk("mac_busy", 64'(o_busy), 64'(1));
            chk("mac_x_ready", 64'(o_x_ready), 64'(0));
         end
         recv(y_obs, lat);
         if (s == 0) chk("latency", 64'(lat), 64'(NTAPS + 1));
         chk("imp_y", 64'($signed(y_obs)), 64'(imp_c[s]));
      end

      // DC gain
      for (int t = 0; t < NTAPS; t++) write_coef(AW'(t), 16'h4000);
      for (int s = 0; s < 10; s++) begin
         send_sample(16'h7FFF, 1'b0, '0, '0);
         recv(y_obs, lat);
         if (s >= NTAPS - 1) chk("dc_y", 64'($signed(y_obs)), 64'(131068));
      end

      // Positive overflow
      for (int t = 0; t < NTAPS; t++) write_coef(AW'(t), 16'h7FFF);
      for (int s = 0; s < NTAPS; s++) begin
         send_sample(16'h7FFF, 1'b0, '0, '0);
         recv(y_obs, lat);
      end
`ifdef FIR_MAC_SAT_EN
      chk("ovf_pos", 64'($signed(y_obs)), 64'(131071));
`else
      chk("ovf_pos", 64'($signed(y_obs)), 64'(-16));
`endif

      // Negative overflow
      for (int s = 0; s < NTAPS; s++) begin
         send_sample(16'h8000, 1'b0, '0, '0);
         recv(y_obs, lat);
      end
`ifdef FIR_MAC_SAT_EN
      chk("ovf_neg", 64'($signed(y_obs)), 64'(-131072));
`else
      chk("ovf_neg", 64'($signed(y_obs)), 64'(8));
`endif

      // Coefficient write on the same cycle as a sample transfer
      for (int t = 0; t < NTAPS; t++) write_coef(AW'(t), 16'h0000);
      send_sample(16'h4000, 1'b1, AW'(0), 16'h2000);
      recv(y_obs, lat);
      chk("wr_xfer_y", 64'($signed(y_obs)), 64'(4096));

      // Backpressure
      i_y_ready = 1'b0;
      send_sample(16'h1234, 1'b0, '0, '0);
      stale = 0;
      while (o_y_valid !== 1'b1 && stale < 100) begin
         @(negedge clk);
         stale++;
      end
      y_hold    = o_y;
      i_x_valid = 1'b1;
      i_x       = 16'h5555;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", 64'(o_y_valid), 64'(1));
         chk("bp_y_stable", 64'(o_y), 64'(y_hold));
         chk("bp_x_ready", 64'(o_x_ready), 64'(0));
      end
      chk("bp_y", 64'($signed(o_y)), 64'($signed(exp_q.pop_front())));
      i_y_ready = 1'b1;
      i_x_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid_drop", 64'(o_y_valid), 64'(0));
      chk("bp_x_ready_up", 64'(o_x_ready), 64'(1));

      // Coefficient write during MAC is rejected
      for (int t = 0; t < NTAPS; t++) write_coef(AW'(t), imp_h[t]);
      for (int s = 0; s < NTAPS - 1; s++) begin
         send_sample(16'h0000, 1'b0, '0, '0);
         recv(y_obs, lat);
      end
      send_sample(16'h7FFF, 1'b0, '0, '0);
      i_c_we   = 1'b1;
      i_c_addr = AW'(3);
      i_c_data = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      i_c_we = 1'b0;
      chk("mac_wr_err", 64'(o_c_err), 64'(1));
      @(negedge clk);
      chk("mac_wr_err_once", 64'(o_c_err), 64'(0));
      recv(y_obs, lat);
      for (int s = 0; s < 3; s++) begin
         send_sample(16'h0000, 1'b0, '0, '0);
         recv(y_obs, lat);
      end
      chk("h3_unchanged", 64'($signed(y_obs)), 64'(29));

      // Random coefficients and samples
      for (int t = 0; t < NTAPS; t++) write_coef(AW'(t), CW'($urandom_range(0, 65535)));
      for (int s = 0; s < 6; s++) begin
         send_sample(DW'($urandom_range(0, 65535)), 1'b0, '0, '0);
         recv(y_obs, lat);
      end

      // Reset mid-MAC
      send_sample(16'h7FFF, 1'b0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      i_rst = 1'b0;
      #1;
      reset_model();
      chk("mid_rst_y", 64'(o_y), 64'(0));
      chk("mid_rst_y_valid", 64'(o_y_valid), 64'(0));
      chk("mid_rst_x_ready", 64'(o_x_ready), 64'(0));
      chk("mid_rst_busy", 64'(o_busy), 64'(0));
      chk("mid_rst_c_err", 64'(o_c_err), 64'(0));
      @(negedge clk);
      @(negedge clk);
      i_rst = 1'b1;
      stale = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (o_y_valid === 1'b1) stale++;
      end
      chk("no_stale_valid", 64'(stale), 64'(0));
      send_sample(16'h7FFF, 1'b0, '0, '0);
      recv(y_obs, lat);
      chk("zero_coef_y", 64'($signed(y_obs)), 64'(0));

      chk("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
